// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: word memory with an independent fetch port and data port, pipelined reads.
// Define MEM_RESP_ERR_CHECK_EN to compile in range/alignment checking that drives mem_err.
module cpu_mem_responder #(
   parameter int DEPTH_WORDS = 4096,
   parameter int RD_LATENCY  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instruction_address,
   input  logic        instruction_enable,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic [31:0] address,
   input  logic        read_enable,
   output logic [31:0] read_data,
   output logic        read_valid,
   input  logic [31:0] write_data,
   input  logic [3:0]  byte_enables,
   input  logic        write_enable,
   output logic        mem_err
);
   localparam int          IDX_W    = $clog2(DEPTH_WORDS);
   localparam int          ERR_D    = (RD_LATENCY > 1) ? RD_LATENCY - 1 : 1;
   localparam int          LAST_IN  = ERR_D - 1;
   localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

   logic [31:0]           mem_r [DEPTH_WORDS];
   logic [IDX_W-1:0]      if_idx_s;
   logic [IDX_W-1:0]      da_idx_s;
   logic                  if_err_s;
   logic                  da_err_s;
   logic [31:0]           if_word_s;
   logic [31:0]           rd_word_s;
   logic [31:0]           if_data_r [RD_LATENCY];
   logic [31:0]           rd_data_r [RD_LATENCY];
   logic [RD_LATENCY-1:0] if_vld_r;
   logic [RD_LATENCY-1:0] rd_vld_r;
   logic [ERR_D-1:0]      if_err_r;
   logic [ERR_D-1:0]      rd_err_r;
   logic                  if_err_last_s;
   logic                  rd_err_last_s;
   logic                  mem_err_r;

   assign if_idx_s = instruction_address[IDX_W+1:2];
   assign da_idx_s = address[IDX_W+1:2];

`ifdef MEM_RESP_ERR_CHECK_EN
   localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);

   // Flag out-of-range word indices and non-word-aligned byte addresses.
   always_comb begin
      if_err_s = (instruction_address[31:2] >= DEPTH_L) || (instruction_address[1:0] != 2'b00);
      da_err_s = (address[31:2] >= DEPTH_L) || (address[1:0] != 2'b00);
   end
`else
   logic unused_addr_s;

   // Checking compiled out: indices wrap and the low address bits are don't-care.
   always_comb begin
      if_err_s      = 1'b0;
      da_err_s      = 1'b0;
      unused_addr_s = ^{instruction_address[31:IDX_W+2], instruction_address[1:0],
                        address[31:IDX_W+2], address[1:0]};
   end
`endif

   // Array read before this edge's write lands, which gives read-first behaviour.
   always_comb begin
      if (if_err_s) begin
         if_word_s = ERR_WORD;
      end else begin
         if_word_s = mem_r[if_idx_s];
      end
      if (da_err_s) begin
         rd_word_s = ERR_WORD;
      end else begin
         rd_word_s = mem_r[da_idx_s];
      end
   end

   // Byte-lane store; memory has no reset so its contents survive rst.
   always_ff @(posedge clk) begin
      if (!rst && write_enable && !da_err_s) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_enables[i]) begin
               mem_r[da_idx_s][8*i +: 8] <= write_data[8*i +: 8];
            end
         end
      end
   end

   // Read pipelines; data stages only load on a valid so the last stage holds its value.
   always_ff @(posedge clk) begin
      if (rst) begin
         if_vld_r <= {RD_LATENCY{1'b0}};
         rd_vld_r <= {RD_LATENCY{1'b0}};
         for (int k = 0; k < RD_LATENCY; k++) begin
            if_data_r[k] <= 32'h0;
            rd_data_r[k] <= 32'h0;
         end
      end else begin
         if_vld_r[0] <= instruction_enable;
         rd_vld_r[0] <= read_enable;
         if (instruction_enable) begin
            if_data_r[0] <= if_word_s;
         end
         if (read_enable) begin
            rd_data_r[0] <= rd_word_s;
         end
         for (int k = 1; k < RD_LATENCY; k++) begin
            if_vld_r[k] <= if_vld_r[k-1];
            rd_vld_r[k] <= rd_vld_r[k-1];
            if (if_vld_r[k-1]) begin
               if_data_r[k] <= if_data_r[k-1];
            end
            if (rd_vld_r[k-1]) begin
               rd_data_r[k] <= rd_data_r[k-1];
            end
         end
      end
   end

   // Error flags that feed the final stage on this edge (stage input, not stage output).
   always_comb begin
      if (RD_LATENCY == 1) begin
         if_err_last_s = instruction_enable & if_err_s;
         rd_err_last_s = read_enable & da_err_s;
      end else begin
         if_err_last_s = if_err_r[LAST_IN];
         rd_err_last_s = rd_err_r[LAST_IN];
      end
   end

   // Error pipeline one stage short of the data pipe so mem_err lines up with the valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         if_err_r  <= {ERR_D{1'b0}};
         rd_err_r  <= {ERR_D{1'b0}};
         mem_err_r <= 1'b0;
      end else begin
         if_err_r[0] <= instruction_enable & if_err_s;
         rd_err_r[0] <= read_enable & da_err_s;
         for (int k = 1; k < ERR_D; k++) begin
            if_err_r[k] <= if_err_r[k-1];
            rd_err_r[k] <= rd_err_r[k-1];
         end
         mem_err_r <= if_err_last_s | rd_err_last_s | (write_enable & da_err_s);
      end
   end

   assign instr       = if_data_r[RD_LATENCY-1];
   assign instr_valid = if_vld_r[RD_LATENCY-1];
   assign read_data   = rd_data_r[RD_LATENCY-1];
   assign read_valid  = rd_vld_r[RD_LATENCY-1];
   assign mem_err     = mem_err_r;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: two instances (RD_LATENCY 1 and 3) share one stimulus stream.
// Expectations follow MEM_RESP_ERR_CHECK_EN when the bundle is compiled with it defined.
module tb_cpu_mem_responder;
`ifdef MEM_RESP_ERR_CHECK_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instruction_address;
   logic        instruction_enable;
   logic [31:0] address;
   logic        read_enable;
   logic [31:0] write_data;
   logic [3:0]  byte_enables;
   logic        write_enable;
   logic [31:0] instr_1, read_data_1, instr_3, read_data_3;
   logic        instr_valid_1, read_valid_1, mem_err_1;
   logic        instr_valid_3, read_valid_3, mem_err_3;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   cpu_mem_responder #(.DEPTH_WORDS(4096), .RD_LATENCY(1)) u_dut_l1 (
      .clk(clk), .rst(rst),
      .instruction_address(instruction_address), .instruction_enable(instruction_enable),
      .instr(instr_1), .instr_valid(instr_valid_1),
      .address(address), .read_enable(read_enable),
      .read_data(read_data_1), .read_valid(read_valid_1),
      .write_data(write_data), .byte_enables(byte_enables), .write_enable(write_enable),
      .mem_err(mem_err_1)
   );

   cpu_mem_responder #(.DEPTH_WORDS(4096), .RD_LATENCY(3)) u_dut_l3 (
      .clk(clk), .rst(rst),
      .instruction_address(instruction_address), .instruction_enable(instruction_enable),
      .instr(instr_3), .instr_valid(instr_valid_3),
      .address(address), .read_enable(read_enable),
      .read_data(read_data_3), .read_valid(read_valid_3),
      .write_data(write_data), .byte_enables(byte_enables), .write_enable(write_enable),
      .mem_err(mem_err_3)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_req();
      instruction_enable = 1'b0;
      read_enable        = 1'b0;
      write_enable       = 1'b0;
   endtask

   task automatic check_all_zero();
      check_val("rst_instr_l1", instr_1, 32'h0);
      check_val("rst_ivalid_l1", {31'h0, instr_valid_1}, 32'h0);
      check_val("rst_rdata_l1", read_data_1, 32'h0);
      check_val("rst_rvalid_l1", {31'h0, read_valid_1}, 32'h0);
      check_val("rst_err_l1", {31'h0, mem_err_1}, 32'h0);
      check_val("rst_instr_l3", instr_3, 32'h0);
      check_val("rst_ivalid_l3", {31'h0, instr_valid_3}, 32'h0);
      check_val("rst_rdata_l3", read_data_3, 32'h0);
      check_val("rst_rvalid_l3", {31'h0, read_valid_3}, 32'h0);
      check_val("rst_err_l3", {31'h0, mem_err_3}, 32'h0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                     input logic exp_err);
      address      = a;
      write_data   = d;
      byte_enables = be;
      write_enable = 1'b1;
      tick();
      clear_req();
      check_val("wr_err_l1", {31'h0, mem_err_1}, {31'h0, exp_err});
      check_val("wr_err_l3", {31'h0, mem_err_3}, {31'h0, exp_err});
      tick();
      check_val("wr_err_pulse_l1", {31'h0, mem_err_1}, 32'h0);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic exp_err);
      address     = a;
      read_enable = 1'b1;
      tick();
      clear_req();
      check_val("rd_valid_l1", {31'h0, read_valid_1}, 32'h1);
      check_val("rd_data_l1", read_data_1, exp);
      check_val("rd_err_l1", {31'h0, mem_err_1}, {31'h0, exp_err});
      check_val("rd_early_l3", {31'h0, read_valid_3}, 32'h0);
      tick();
      check_val("rd_pulse_l1", {31'h0, read_valid_1}, 32'h0);
      check_val("rd_hold_l1", read_data_1, exp);
      check_val("rd_early2_l3", {31'h0, read_valid_3}, 32'h0);
      tick();
      check_val("rd_valid_l3", {31'h0, read_valid_3}, 32'h1);
      check_val("rd_data_l3", read_data_3, exp);
      check_val("rd_err_l3", {31'h0, mem_err_3}, {31'h0, exp_err});
   endtask

   task automatic fe(input logic [31:0] a, input logic [31:0] exp, input logic exp_err);
      instruction_address = a;
      instruction_enable  = 1'b1;
      tick();
      clear_req();
      check_val("fe_valid_l1", {31'h0, instr_valid_1}, 32'h1);
      check_val("fe_data_l1", instr_1, exp);
      check_val("fe_err_l1", {31'h0, mem_err_1}, {31'h0, exp_err});
      check_val("fe_early_l3", {31'h0, instr_valid_3}, 32'h0);
      tick();
      check_val("fe_pulse_l1", {31'h0, instr_valid_1}, 32'h0);
      check_val("fe_hold_l1", instr_1, exp);
      tick();
      check_val("fe_valid_l3", {31'h0, instr_valid_3}, 32'h1);
      check_val("fe_data_l3", instr_3, exp);
      check_val("fe_err_l3", {31'h0, mem_err_3}, {31'h0, exp_err});
   endtask

   initial begin
      // Reset with fetch/read requests present: they must never return.
      rst                 = 1'b1;
      instruction_address = 32'h0;
      instruction_enable  = 1'b1;
      address             = 32'h0;
      read_enable         = 1'b1;
      write_data          = 32'h0;
      byte_enables        = 4'h0;
      write_enable        = 1'b0;
      tick();
      tick();
      check_all_zero();
      rst = 1'b0;
      clear_req();
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("post_rst_ivalid_l1", {31'h0, instr_valid_1}, 32'h0);
         check_val("post_rst_rvalid_l3", {31'h0, read_valid_3}, 32'h0);
         check_val("post_rst_ivalid_l3", {31'h0, instr_valid_3}, 32'h0);
      end

      // Preload known words.
      wr(32'h0000, 32'hCAFE_F00D, 4'hF, 1'b0);
      wr(32'h0004, 32'h1111_0004, 4'hF, 1'b0);
      wr(32'h0008, 32'h2222_0008, 4'hF, 1'b0);
      wr(32'h0200, 32'h0000_0000, 4'hF, 1'b0);
      wr(32'h0300, 32'h0BAD_F00D, 4'hF, 1'b0);

      // Full write then read; partial lanes; empty byte mask.
      wr(32'h0100, 32'h1122_3344, 4'hF, 1'b0);
      rd(32'h0100, 32'h1122_3344, 1'b0);
      wr(32'h0100, 32'hAABB_CCDD, 4'b0101, 1'b0);
      rd(32'h0100, 32'h11BB_33DD, 1'b0);
      wr(32'h0100, 32'hFFFF_FFFF, 4'b0000, 1'b0);
      rd(32'h0100, 32'h11BB_33DD, 1'b0);

      // Read and write of the same word on one edge: read-first.
      write_data   = 32'h7777_7777;
      byte_enables = 4'hF;
      write_enable = 1'b1;
      rd(32'h0100, 32'h11BB_33DD, 1'b0);
      rd(32'h0100, 32'h7777_7777, 1'b0);

      // Fetch of a word written on the same edge sees the old value.
      address      = 32'h0200;
      write_data   = 32'h0000_0005;
      byte_enables = 4'hF;
      write_enable = 1'b1;
      fe(32'h0200, 32'h0000_0000, 1'b0);
      fe(32'h0200, 32'h0000_0005, 1'b0);

      // Back-to-back fetches with a concurrent data read.
      instruction_address = 32'h0;
      instruction_enable  = 1'b1;
      address             = 32'h0100;
      read_enable         = 1'b1;
      tick();
      read_enable         = 1'b0;
      instruction_address = 32'h4;
      check_val("b2b_e0_instr_l1", instr_1, 32'hCAFE_F00D);
      check_val("b2b_e0_ivalid_l1", {31'h0, instr_valid_1}, 32'h1);
      check_val("b2b_e0_rdata_l1", read_data_1, 32'h7777_7777);
      check_val("b2b_e0_rvalid_l1", {31'h0, read_valid_1}, 32'h1);
      tick();
      instruction_address = 32'h8;
      check_val("b2b_e1_instr_l1", instr_1, 32'h1111_0004);
      check_val("b2b_e1_rvalid_l1", {31'h0, read_valid_1}, 32'h0);
      check_val("b2b_e1_ivalid_l3", {31'h0, instr_valid_3}, 32'h0);
      tick();
      instruction_enable = 1'b0;
      check_val("b2b_e2_instr_l1", instr_1, 32'h2222_0008);
      check_val("b2b_e2_ivalid_l3", {31'h0, instr_valid_3}, 32'h1);
      check_val("b2b_e2_instr_l3", instr_3, 32'hCAFE_F00D);
      check_val("b2b_e2_rvalid_l3", {31'h0, read_valid_3}, 32'h1);
      check_val("b2b_e2_rdata_l3", read_data_3, 32'h7777_7777);
      tick();
      check_val("b2b_e3_ivalid_l1", {31'h0, instr_valid_1}, 32'h0);
      check_val("b2b_e3_instr_l1", instr_1, 32'h2222_0008);
      check_val("b2b_e3_ivalid_l3", {31'h0, instr_valid_3}, 32'h1);
      check_val("b2b_e3_instr_l3", instr_3, 32'h1111_0004);
      check_val("b2b_e3_rvalid_l3", {31'h0, read_valid_3}, 32'h0);
      tick();
      check_val("b2b_e4_ivalid_l3", {31'h0, instr_valid_3}, 32'h1);
      check_val("b2b_e4_instr_l3", instr_3, 32'h2222_0008);
      tick();
      check_val("b2b_e5_ivalid_l3", {31'h0, instr_valid_3}, 32'h0);
      check_val("b2b_e5_instr_l3", instr_3, 32'h2222_0008);

      // Read in flight when reset arrives; requests during reset are ignored.
      address     = 32'h0100;
      read_enable = 1'b1;
      tick();
      rst                 = 1'b1;
      address             = 32'h0300;
      write_data          = 32'hFFFF_FFFF;
      byte_enables        = 4'hF;
      write_enable        = 1'b1;
      instruction_address = 32'h0300;
      instruction_enable  = 1'b1;
      tick();
      rst = 1'b0;
      clear_req();
      check_all_zero();
      for (int i = 0; i < 2; i++) begin
         tick();
         check_val("flush_rvalid_l1", {31'h0, read_valid_1}, 32'h0);
         check_val("flush_rvalid_l3", {31'h0, read_valid_3}, 32'h0);
         check_val("flush_ivalid_l3", {31'h0, instr_valid_3}, 32'h0);
      end
      rd(32'h0300, 32'h0BAD_F00D, 1'b0);

      // Out-of-range and misaligned accesses.
      rd(32'h4000, ERR_ON ? 32'hDEAD_BEEF : 32'hCAFE_F00D, ERR_ON);
      rd(32'h0102, ERR_ON ? 32'hDEAD_BEEF : 32'h7777_7777, ERR_ON);
      fe(32'h0202, ERR_ON ? 32'hDEAD_BEEF : 32'h0000_0005, ERR_ON);
      wr(32'h4000, 32'h1234_5678, 4'hF, ERR_ON);
      rd(32'h0000, ERR_ON ? 32'hCAFE_F00D : 32'h1234_5678, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, number of 32-bit words of backing memory (power of two).
REQ-002 SHALL have parameter RD_LATENCY, default 1, cycles from sampled read request to returned data (legal 1..4).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port instruction_address  input  32  fetch byte address.
REQ-006 SHALL have port instruction_enable  input  1  fetch request strobe.
REQ-007 SHALL have port instr  output  32  fetched instruction word.
REQ-008 SHALL have port instr_valid  output  1  one-cycle strobe: instr updated.
REQ-009 SHALL have port address  input  32  data byte address.
REQ-010 SHALL have port read_enable  input  1  data read request strobe.
REQ-011 SHALL have port read_data  output  32  returned data word.
REQ-012 SHALL have port read_valid  output  1  one-cycle strobe: read_data updated.
REQ-013 SHALL have port write_data  input  32  store data, byte lane i = bits 8i+7:8i.
REQ-014 SHALL have port byte_enables  input  4  per-lane write enable.
REQ-015 SHALL have port write_enable  input  1  data write request strobe.
REQ-016 SHALL have port mem_err  output  1  access-error strobe (see Configuration).

Function
REQ-017 SHALL form word index as address[31:2] for both ports; fetch and data ports operate independently every cycle.
REQ-018 SHALL sample a fetch when instruction_enable=1 at edge N and drive instr plus instr_valid=1 for exactly one cycle after edge N+RD_LATENCY-1.
REQ-019 SHALL sample a data read when read_enable=1 at edge N and drive read_data plus read_valid=1 on the same timing as REQ-018.
REQ-020 SHALL accept one new request per port per cycle, fully pipelined; results return in request order.
REQ-021 SHALL hold instr and read_data at their last returned values when the corresponding valid is 0.
REQ-022 SHALL, on write_enable=1 at edge N, update only the lanes with byte_enables[i]=1; byte_enables=4'b0000 writes nothing.
REQ-023 SHALL be read-first: a read (either port) of a word written at the same edge returns pre-write contents.
REQ-024 SHALL treat read_enable and write_enable both high as a read-first read plus a write to the same address.
REQ-025 SHALL return post-write contents for any read sampled at an edge after the write edge, regardless of RD_LATENCY.
REQ-026 SHALL hold mem_err at 0 except as defined in REQ-031.

Reset
REQ-027 SHALL, while rst=1 at an edge, clear instr, read_data to 32'h0 and instr_valid, read_valid, mem_err to 0.
REQ-028 SHALL discard all in-flight read requests on reset; no valid strobe for them after rst deasserts.
REQ-029 SHALL ignore fetch, read and write requests presented during a reset cycle; memory contents are preserved across reset.

Configuration
REQ-030 SHALL use macro MEM_RESP_ERR_CHECK_EN to compile access checking in or out.
REQ-031 SHALL, with MEM_RESP_ERR_CHECK_EN defined: flag a request whose word index >= DEPTH_WORDS, or a data read/write with address[1:0]!=0, or a fetch with instruction_address[1:0]!=0; a flagged write is suppressed; a flagged read returns 32'hDEAD_BEEF; mem_err pulses one cycle aligned with the flagged read's valid, or one cycle after the edge sampling a flagged write.
REQ-032 SHALL, without MEM_RESP_ERR_CHECK_EN: tie mem_err to 0, ignore address[1:0], wrap word index modulo DEPTH_WORDS.

Verification
REQ-033 SHALL cover: write 32'h1122_3344, byte_enables=4'hF to 0x100; read 0x100 next cycle -> read_valid after RD_LATENCY cycles, read_data=32'h1122_3344.
REQ-034 SHALL cover: write 32'hAABB_CCDD, byte_enables=4'b0101 to 0x100 (above) -> later read returns 32'h11BB_33DD.
REQ-035 SHALL cover: same-edge write 32'h5 and fetch of 0x200 (old 32'h0) -> instr=32'h0; fetch next cycle -> instr=32'h5.
REQ-036 SHALL cover: back-to-back fetches 0x0,0x4,0x8 with RD_LATENCY=3 -> three consecutive instr_valid pulses, data in order.
REQ-037 SHALL cover: read issued, rst asserted next cycle -> no read_valid ever for it; outputs 0 after reset.
REQ-038 SHALL cover: MEM_RESP_ERR_CHECK_EN defined, DEPTH_WORDS=4096, read 0x4000 -> read_data=32'hDEAD_BEEF, mem_err=1 with read_valid; undefined -> read returns word 0 contents, mem_err=0.
